// File: rtl/sar_pkg.sv
// ============================================================================
// sar_pkg : shared state encoding and default width for sar_search
// Revision: 1.0
// ============================================================================
`default_nettype none

package sar_pkg;

  localparam int unsigned SAR_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRY    = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } sar_state_e;

endpackage

`default_nettype wire

// File: rtl/sar_search.sv
// ============================================================================
// sar_search : successive-approximation search driving an external comparator
// Revision: 1.0
// ============================================================================
`default_nettype none

module sar_search
  import sar_pkg::*;
#(
  parameter int unsigned W = SAR_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_gt_b,
  input  logic         a_ls_b,
  input  logic         a_eq_b,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int unsigned IW = $clog2(W);
  localparam logic [W-1:0] MSB_ONLY = {1'b1, {(W-1){1'b0}}};

  sar_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  cand_q, cand_d;
  logic [W-1:0]  guess_q, guess_d;
  logic [W-1:0]  result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic          err_q, err_d;

  logic          flags_ok;
  logic [W-1:0]  cand_upd;

  assign flags_ok = $onehot({a_gt_b, a_ls_b, a_eq_b});

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    guess_d  = guess_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    cand_upd = cand_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cand_d   = MSB_ONLY;
          guess_d  = MSB_ONLY;
          idx_d    = IW'(W - 1);
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = TRY;
        end
      end

      TRY: begin
        if (!flags_ok) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = guess_q;
          state_d  = DONE;
        end else if (a_eq_b) begin
          found_d  = 1'b1;
          result_d = guess_q;
          state_d  = DONE;
        end else begin
          // cand always carries the trial bit, so a_gt_b just leaves it set
          if (a_ls_b) begin
            cand_upd[idx_q] = 1'b0;
          end
          if (idx_q == '0) begin
            cand_d  = cand_upd;
            guess_d = cand_upd;
            state_d = VERIFY;
          end else begin
            cand_upd[idx_q - 1'b1] = 1'b1;
            cand_d  = cand_upd;
            guess_d = cand_upd;
            idx_d   = idx_q - 1'b1;
          end
        end
      end

      VERIFY: begin
        result_d = guess_q;
        err_d    = !flags_ok;
        found_d  = flags_ok && a_eq_b;
        state_d  = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == TRY) || (state_d == VERIFY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cand_q   <= '0;
      guess_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_search.sv
// ============================================================================
// tb_sar_search : directed self-checking bench for sar_search (W=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sar_search;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] target = '0;
  logic         force_en = 1'b0;
  logic [2:0]   force_flags = 3'b000;
  logic         a_gt_b, a_ls_b, a_eq_b;
  logic [W-1:0] guess, result;
  logic         busy, done, found, err;

  int total = 0;
  int bad = 0;
  logic [W-1:0] g_seen [0:7];
  int cyc;

  // Reference comparator: a = target, b = guess, with a flag override
  assign a_gt_b = force_en ? force_flags[2] : (target > guess);
  assign a_ls_b = force_en ? force_flags[1] : (target < guess);
  assign a_eq_b = force_en ? force_flags[0] : (target == guess);

  sar_search #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_gt_b (a_gt_b),
    .a_ls_b (a_ls_b),
    .a_eq_b (a_eq_b),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch a search from IDLE, record guesses, wait for done, then return in IDLE
  task automatic run(input logic [W-1:0] t, input bit hold_start);
    target = t;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    g_seen[0] = guess;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 8) g_seen[cyc] = guess;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("reset_guess", {28'd0, guess}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_found", {31'd0, found}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_result", {28'd0, result}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // target 8: equality on first compare
    run(4'd8, 1'b0);
    chk("t8_g0", {28'd0, g_seen[0]}, 32'd8);
    chk("t8_cycles", cyc, 32'd1);
    chk("t8_found", {31'd0, found}, 32'd1);
    chk("t8_result", {28'd0, result}, 32'd8);
    chk("t8_err", {31'd0, err}, 32'd0);

    // target 5: 8 ls, 4 gt, 6 ls, 5 eq
    run(4'd5, 1'b0);
    chk("t5_g0", {28'd0, g_seen[0]}, 32'd8);
    chk("t5_g1", {28'd0, g_seen[1]}, 32'd4);
    chk("t5_g2", {28'd0, g_seen[2]}, 32'd6);
    chk("t5_g3", {28'd0, g_seen[3]}, 32'd5);
    chk("t5_cycles", cyc, 32'd4);
    chk("t5_found", {31'd0, found}, 32'd1);
    chk("t5_result", {28'd0, result}, 32'd5);

    // target 0: four ls, VERIFY at 0
    run(4'd0, 1'b0);
    chk("t0_g1", {28'd0, g_seen[1]}, 32'd4);
    chk("t0_g2", {28'd0, g_seen[2]}, 32'd2);
    chk("t0_g3", {28'd0, g_seen[3]}, 32'd1);
    chk("t0_g4", {28'd0, g_seen[4]}, 32'd0);
    chk("t0_cycles", cyc, 32'd5);
    chk("t0_found", {31'd0, found}, 32'd1);
    chk("t0_result", {28'd0, result}, 32'd0);

    // target 15: 8, 12, 14, 15
    run(4'd15, 1'b0);
    chk("t15_g1", {28'd0, g_seen[1]}, 32'd12);
    chk("t15_g2", {28'd0, g_seen[2]}, 32'd14);
    chk("t15_g3", {28'd0, g_seen[3]}, 32'd15);
    chk("t15_cycles", cyc, 32'd4);
    chk("t15_found", {31'd0, found}, 32'd1);
    chk("t15_result", {28'd0, result}, 32'd15);

    // exhaustive sweep plus random targets
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] t;
      t = (i < 16) ? W'(i) : W'($urandom_range(15, 0));
      run(t, 1'b0);
      chk("sweep_result", {28'd0, result}, {28'd0, t});
      chk("sweep_found", {31'd0, found}, 32'd1);
    end

    // no flags during second TRY
    target = 4'd5;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    chk("err0_second_guess", {28'd0, guess}, 32'd4);
    force_en = 1'b1; force_flags = 3'b000;
    @(posedge clk); #1;
    force_en = 1'b0;
    chk("err0_done", {31'd0, done}, 32'd1);
    chk("err0_err", {31'd0, err}, 32'd1);
    chk("err0_found", {31'd0, found}, 32'd0);
    chk("err0_result", {28'd0, result}, 32'd4);
    @(posedge clk); #1;

    // next start clears err
    run(4'd3, 1'b0);
    chk("err_cleared", {31'd0, err}, 32'd0);
    chk("after_err_result", {28'd0, result}, 32'd3);

    // gt and eq together during second TRY
    target = 4'd9;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    force_en = 1'b1; force_flags = 3'b101;
    @(posedge clk); #1;
    force_en = 1'b0;
    chk("err2_done", {31'd0, done}, 32'd1);
    chk("err2_err", {31'd0, err}, 32'd1);
    chk("err2_found", {31'd0, found}, 32'd0);
    chk("err2_result", {28'd0, result}, 32'd12);
    @(posedge clk); #1;

    // start held during busy: sequence unaffected; relaunch only from IDLE
    target = 4'd5;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    g_seen[0] = guess;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 8) g_seen[cyc] = guess;
    end
    chk("hold_g1", {28'd0, g_seen[1]}, 32'd4);
    chk("hold_g2", {28'd0, g_seen[2]}, 32'd6);
    chk("hold_cycles", cyc, 32'd4);
    chk("hold_result", {28'd0, result}, 32'd5);
    @(posedge clk); #1;
    chk("hold_idle_busy", {31'd0, busy}, 32'd0);
    chk("hold_idle_guess", {28'd0, guess}, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_relaunch_busy", {31'd0, busy}, 32'd1);
    chk("hold_relaunch_guess", {28'd0, guess}, 32'd8);
    chk("hold_relaunch_result", {28'd0, result}, 32'd0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_relaunch_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;

    // asynchronous reset mid-TRY
    target = 4'd9;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_guess", {28'd0, guess}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_found", {31'd0, found}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_result", {28'd0, result}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk) rst = 1'b0;

    run(4'd10, 1'b0);
    chk("post_rst_result", {28'd0, result}, 32'd10);
    chk("post_rst_cycles", cyc, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
